// File: rtl/ctrl_pkg.sv
// Shared control types for the I2S transmit path: the OP control word,
// the serializer state encoding and frame-length helpers.
package ctrl_pkg;

    // Frame lengths in sclk cycles for the two supported word sizes.
    localparam int FRAME32_LEN = 32;
    localparam int FRAME16_LEN = 16;

    // Operating mode: master/slave, receive/transmit.
    typedef enum logic [1:0] {
        MODE_MR = 2'd0,
        MODE_MT = 2'd1,
        MODE_SR = 2'd2,
        MODE_ST = 2'd3
    } mode_t;

    // Serial data standard. Only I2S shifts data one sclk after the slot edge.
    typedef enum logic [1:0] {
        I2S   = 2'd0,
        MSB_J = 2'd1,
        LSB_J = 2'd2
    } standard_t;

    typedef enum logic {
        f16bits = 1'b0,
        f32bits = 1'b1
    } frame_size_t;

    typedef struct packed {
        mode_t       mode;
        standard_t   standard;
        frame_size_t frame_size;
        logic        stop;
    } OP_t;

    // Serializer FSM states.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    // Number of bits shifted per word for a given frame size.
    function automatic logic [5:0] frame_len(input frame_size_t fs);
        return (fs == f16bits) ? 6'(FRAME16_LEN) : 6'(FRAME32_LEN);
    endfunction

endpackage

// File: rtl/i2s_tx_shift_reg.sv
// tx_shift_reg: loadable shift register for the I2S transmit path.
// Shift direction is captured at load and held for the whole word; the tap
// presents the bit that is next on the wire (MSB for left shift, LSB for right).
module tx_shift_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              load,
    input  logic              shift,
    input  logic              load_lsb,
    input  logic [DATA_W-1:0] load_data,
    output logic              tap
);

    logic [DATA_W-1:0] q;
    logic              lsb_q;

    // Load a new word (and its direction) or shift one position, zero fill.
    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            q     <= '0;
            lsb_q <= 1'b0;
        end else if (load) begin
            q     <= load_data;
            lsb_q <= load_lsb;
        end else if (shift) begin
            if (lsb_q) begin
                q <= {1'b0, q[DATA_W-1:1]};
            end else begin
                q <= {q[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Tap selection follows the latched direction.
    assign tap = lsb_q ? q[0] : q[DATA_W-1];

endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: pops one word per channel slot from the FWFT Tx FIFO
// and shifts it out on sd, MSB-first by default. All state moves on the
// falling edge of sclk. The first bit of a word is on sd right after the
// edge that loads it, so back-to-back words leave no gap bit.
//
// Build option: define TX_LSB_FIRST_EN to add the lsb_first input, which
// selects LSB-first shifting for the word being loaded.
//
// FIFO handshake: fifo_rdata is taken as valid whenever fifo_empty is low;
// fifo_rd is a one-sclk pop strobe registered on the load edge and is never
// raised while the FIFO is empty.
module i2s_tx_serializer
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              sclk,
    input  logic              rst_,
    input  OP_t               OP,
    input  logic              Tx_ren,
    input  logic              del_Tx_ren,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_empty,
    input  logic              underrun_clr,
`ifdef TX_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              fifo_rd,
    output logic              sd,
    output logic              busy,
    output logic              underrun
);

    ser_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  last_cnt_q;
    logic              mode_tx;
    logic              en;
    logic              start_ok;
    logic              last_bit;
    logic              load;
    logic              shift;
    logic              load_lsb;
    logic              frame16;
    logic [DATA_W-1:0] load_word;
    logic              tap;

`ifdef TX_LSB_FIRST_EN
    assign load_lsb = lsb_first;
`else
    assign load_lsb = 1'b0;
`endif

    // Slot enable: I2S data lags the word-select edge by one sclk.
    assign mode_tx  = (OP.mode == MODE_MT) || (OP.mode == MODE_ST);
    assign en       = mode_tx && ((OP.standard == I2S) ? del_Tx_ren : Tx_ren);
    assign start_ok = en && !OP.stop;
    assign last_bit = (cnt_q == last_cnt_q);
    assign frame16  = (OP.frame_size == f16bits);

    // Word to load: zeros on underrun; 16-bit frames aligned to the tap end.
    always_comb begin
        load_word = fifo_rdata;
        if (fifo_empty) begin
            load_word = '0;
        end else if (frame16) begin
            if (load_lsb) begin
                load_word = {{(DATA_W-FRAME16_LEN){1'b0}}, fifo_rdata[FRAME16_LEN-1:0]};
            end else begin
                load_word = {fifo_rdata[FRAME16_LEN-1:0], {(DATA_W-FRAME16_LEN){1'b0}}};
            end
        end
    end

    // Next-state logic: load on a slot start, shift until the last bit, then reload or idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (start_ok) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    shift = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, bit counter and per-word frame length.
    always_ff @(negedge sclk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_cnt_q <= CNT_W'(FRAME32_LEN - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                last_cnt_q <= CNT_W'(frame_len(OP.frame_size) - 6'd1);
            end
        end
    end

    // Pop strobe and sticky underrun flag; a new underrun beats a clear.
    always_ff @(negedge sclk or negedge rst_) begin
        if (!rst_) begin
            fifo_rd  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            fifo_rd <= load && !fifo_empty;
            if (load && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    tx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk       (sclk),
        .rst_      (rst_),
        .load      (load),
        .shift     (shift),
        .load_lsb  (load_lsb),
        .load_data (load_word),
        .tap       (tap)
    );

    // Serial output is forced low whenever no word is in flight.
    assign busy = (state_q == S_SHIFT);
    assign sd   = busy & tap;

endmodule
